// File: rtl/a51_keystream_gen_if.sv
// A5/1 keystream generator bus: session control in, keystream out.
// The slave side is the generator; the master side drives it.
interface a51_keystream_gen_if #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int OUT_BITS   = 228
);
    localparam int IW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

    logic                  start;
    logic                  abort;
    logic [KEY_BITS-1:0]   key;
    logic [FRAME_BITS-1:0] frame;
    logic                  ks_bit;
    logic                  ks_valid;
    logic                  ks_ready;
    logic [IW-1:0]         ks_index;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, key, frame, ks_ready,
        input  ks_bit, ks_valid, ks_index, busy, done
    );

    modport slave (
        input  start, abort, key, frame, ks_ready,
        output ks_bit, ks_valid, ks_index, busy, done
    );
endinterface

// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator: parallel key/frame load, majority-clocked
// mix phase, then keystream bits streamed over a valid/ready handshake.
module a51_keystream_gen #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int OUT_BITS   = 228
) (
    input logic clk,
    input logic reset,
    a51_keystream_gen_if.slave bus
);
    localparam int LOAD_N  = KEY_BITS + FRAME_BITS;
    localparam int MAX_A   = (LOAD_N > MIX_CYCLES) ? LOAD_N : MIX_CYCLES;
    localparam int MAX_LEN = (MAX_A > OUT_BITS) ? MAX_A : OUT_BITS;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int IW      = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

    localparam logic [CW-1:0] LOAD_END = CW'(LOAD_N);
    localparam logic [CW-1:0] MIX_LAST = CW'((MIX_CYCLES > 0) ? MIX_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(OUT_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MIX, OUT} state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [LOAD_N-1:0] kf_sh;
    logic [18:0]       r19;
    logic [21:0]       r22;
    logic [22:0]       r23;
    logic [18:0]       r19_n;
    logic [21:0]       r22_n;
    logic [22:0]       r23_n;

    logic accept;
    logic load_clk;
    logic maj_clk;
    logic present;
    logic finish;
    logic kill;

    logic fb19;
    logic fb22;
    logic fb23;
    logic maj;

    assign fb19 = r19[18] ^ r19[17] ^ r19[16] ^ r19[13];
    assign fb22 = r22[21] ^ r22[20];
    assign fb23 = r23[22] ^ r23[21] ^ r23[20] ^ r23[7];
    assign maj  = (r19[8] & r22[10]) | (r19[8] & r23[10]) | (r22[10] & r23[10]);

    assign bus.busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and per-cycle control strobes; LOAD spends one settle
    // cycle after its last shift before handing over to MIX/OUT
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_clk   = 1'b0;
        maj_clk    = 1'b0;
        present    = 1'b0;
        finish     = 1'b0;
        kill       = 1'b0;
        if (state != IDLE && bus.abort) begin
            kill       = 1'b1;
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.done) begin
                        accept     = 1'b1;
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    if (cnt == LOAD_END) state_next = (MIX_CYCLES == 0) ? OUT : MIX;
                    else                 load_clk   = 1'b1;
                end
                MIX: begin
                    maj_clk = 1'b1;
                    if (cnt == MIX_LAST) state_next = OUT;
                end
                OUT: begin
                    if (!bus.ks_valid) begin
                        maj_clk = 1'b1;
                        present = 1'b1;
                    end else if (bus.ks_ready) begin
                        if (bus.ks_index == LAST_IDX) begin
                            finish     = 1'b1;
                            state_next = IDLE;
                        end else begin
                            maj_clk = 1'b1;
                            present = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Next LFSR contents for a load shift or a majority step
    always_comb begin
        r19_n = r19;
        r22_n = r22;
        r23_n = r23;
        if (load_clk) begin
            r19_n = {r19[17:0], fb19 ^ kf_sh[0]};
            r22_n = {r22[20:0], fb22 ^ kf_sh[0]};
            r23_n = {r23[21:0], fb23 ^ kf_sh[0]};
        end else if (maj_clk) begin
            if (r19[8] == maj)  r19_n = {r19[17:0], fb19};
            if (r22[10] == maj) r22_n = {r22[20:0], fb22};
            if (r23[10] == maj) r23_n = {r23[21:0], fb23};
        end
    end

    // Phase counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (reset)                    cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (state == LOAD || state == MIX) cnt <= cnt + CW'(1);
    end

    // LFSRs, key/frame shadow and keystream output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            kf_sh        <= '0;
            r19          <= '0;
            r22          <= '0;
            r23          <= '0;
            bus.ks_bit   <= 1'b0;
            bus.ks_valid <= 1'b0;
            bus.ks_index <= '0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= finish;
            if (accept) begin
                kf_sh <= {bus.frame, bus.key};
                r19   <= '0;
                r22   <= '0;
                r23   <= '0;
            end else begin
                r19 <= r19_n;
                r22 <= r22_n;
                r23 <= r23_n;
                if (load_clk) kf_sh <= kf_sh >> 1;
            end
            if (present) begin
                bus.ks_bit   <= r19_n[18] ^ r22_n[21] ^ r23_n[22];
                bus.ks_valid <= 1'b1;
                bus.ks_index <= bus.ks_valid ? bus.ks_index + IW'(1) : '0;
            end
            if (finish || kill) begin
                bus.ks_valid <= 1'b0;
                bus.ks_index <= '0;
            end
        end
    end
endmodule
